rvfi_retire_emitter: RTL and testbench

//  Producer side of RVFI: collects per-instruction retirement records that a core completes out of order.

---
 rtl/rvfi_retire_emitter.sv | 167 ++++++++++++++++
 tb/tb_rvfi_retire_emitter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_retire_emitter.sv
// Reorder buffer for out-of-order retirement records. It emits them strictly in program order
// on a registered RVFI bus, up to NRET per cycle.
module rvfi_retire_emitter #(
    parameter int unsigned NRET  = 1,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned ILEN  = 32,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned TAG_W = $clog2(DEPTH),
    localparam int unsigned REC_W = ILEN + 18 + 8 * XLEN + XLEN / 4
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [TAG_W-1:0]         in_tag,
    input  logic [REC_W-1:0]         in_rec,
    input  logic                     flush,
    input  logic [TAG_W-1:0]         flush_tag,
    output logic [NRET-1:0]          rvfi_valid,
    output logic [NRET-1:0]          rvfi_trap,
    output logic [NRET-1:0]          rvfi_halt,
    output logic [NRET-1:0]          rvfi_intr,
    output logic [64*NRET-1:0]       rvfi_order,
    output logic [ILEN*NRET-1:0]     rvfi_insn,
    output logic [5*NRET-1:0]        rvfi_rs1_addr,
    output logic [5*NRET-1:0]        rvfi_rs2_addr,
    output logic [5*NRET-1:0]        rvfi_rd_addr,
    output logic [XLEN*NRET-1:0]     rvfi_rs1_rdata,
    output logic [XLEN*NRET-1:0]     rvfi_rs2_rdata,
    output logic [XLEN*NRET-1:0]     rvfi_rd_wdata,
    output logic [XLEN*NRET-1:0]     rvfi_pc_rdata,
    output logic [XLEN*NRET-1:0]     rvfi_pc_wdata,
    output logic [XLEN*NRET-1:0]     rvfi_mem_addr,
    output logic [XLEN/8*NRET-1:0]   rvfi_mem_rmask,
    output logic [XLEN/8*NRET-1:0]   rvfi_mem_wmask,
    output logic [XLEN*NRET-1:0]     rvfi_mem_rdata,
    output logic [XLEN*NRET-1:0]     rvfi_mem_wdata
);
    localparam int unsigned MW    = XLEN / 8;
    localparam int unsigned CNT_W = $clog2(NRET + 1);

    // Field offsets within a record, counted from the LSB (mem_wdata is last).
    localparam int unsigned OFF_WDATA = 0;
    localparam int unsigned OFF_RDATA = XLEN;
    localparam int unsigned OFF_WMASK = 2 * XLEN;
    localparam int unsigned OFF_RMASK = 2 * XLEN + MW;
    localparam int unsigned OFF_MADDR = 2 * XLEN + 2 * MW;
    localparam int unsigned OFF_PCW   = OFF_MADDR + XLEN;
    localparam int unsigned OFF_PCR   = OFF_PCW + XLEN;
    localparam int unsigned OFF_RDW   = OFF_PCR + XLEN;
    localparam int unsigned OFF_RS2D  = OFF_RDW + XLEN;
    localparam int unsigned OFF_RS1D  = OFF_RS2D + XLEN;
    localparam int unsigned OFF_RD    = OFF_RS1D + XLEN;
    localparam int unsigned OFF_RS2A  = OFF_RD + 5;
    localparam int unsigned OFF_RS1A  = OFF_RS2A + 5;
    localparam int unsigned OFF_INTR  = OFF_RS1A + 5;
    localparam int unsigned OFF_HALT  = OFF_INTR + 1;
    localparam int unsigned OFF_TRAP  = OFF_HALT + 1;
    localparam int unsigned OFF_INSN  = OFF_TRAP + 1;

    typedef enum logic {ModeRun, ModeHalted} mode_e;

    logic [DEPTH-1:0] slot_full_q;
    logic [REC_W-1:0] slot_rec_q [DEPTH];
    logic [TAG_W-1:0] head_q;
    logic [63:0]      order_q;
    mode_e            mode_q;

    logic [NRET-1:0]  take;
    logic [TAG_W-1:0] ret_idx [NRET];
    logic [REC_W-1:0] ret_rec [NRET];
    logic [CNT_W-1:0] ret_cnt;
    logic             ret_halt;
    logic             stop;

    assign in_ready = resetn && !slot_full_q[in_tag];

    // Retirement looks only at registered slot state, so a fresh accept never bypasses.
    always_comb begin
        take     = '0;
        ret_cnt  = '0;
        ret_halt = 1'b0;
        stop     = (mode_q == ModeHalted);
        for (int i = 0; i < NRET; i++) begin
            ret_idx[i] = head_q + TAG_W'(i);
            ret_rec[i] = slot_rec_q[ret_idx[i]];
            if (!stop && slot_full_q[ret_idx[i]]) begin
                take[i] = 1'b1;
                ret_cnt = ret_cnt + CNT_W'(1);
                if (ret_rec[i][OFF_HALT]) begin
                    ret_halt = 1'b1;
                    stop     = 1'b1;
                end
            end else begin
                stop = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            slot_full_q    <= '0;
            head_q         <= '0;
            order_q        <= '0;
            mode_q         <= ModeRun;
            rvfi_valid     <= '0;
            rvfi_trap      <= '0;
            rvfi_halt      <= '0;
            rvfi_intr      <= '0;
            rvfi_order     <= '0;
            rvfi_insn      <= '0;
            rvfi_rs1_addr  <= '0;
            rvfi_rs2_addr  <= '0;
            rvfi_rd_addr   <= '0;
            rvfi_rs1_rdata <= '0;
            rvfi_rs2_rdata <= '0;
            rvfi_rd_wdata  <= '0;
            rvfi_pc_rdata  <= '0;
            rvfi_pc_wdata  <= '0;
            rvfi_mem_addr  <= '0;
            rvfi_mem_rmask <= '0;
            rvfi_mem_wmask <= '0;
            rvfi_mem_rdata <= '0;
            rvfi_mem_wdata <= '0;
        end else if (flush) begin
            slot_full_q <= '0;
            head_q      <= flush_tag;
            rvfi_valid  <= '0;
        end else begin
            rvfi_valid <= take;
            for (int i = 0; i < NRET; i++) begin
                if (take[i]) begin
                    slot_full_q[ret_idx[i]]         <= 1'b0;
                    rvfi_order[i*64 +: 64]          <= order_q + 64'(i);
                    rvfi_insn[i*ILEN +: ILEN]       <= ret_rec[i][OFF_INSN +: ILEN];
                    rvfi_trap[i]                    <= ret_rec[i][OFF_TRAP];
                    rvfi_halt[i]                    <= ret_rec[i][OFF_HALT];
                    rvfi_intr[i]                    <= ret_rec[i][OFF_INTR];
                    rvfi_rs1_addr[i*5 +: 5]         <= ret_rec[i][OFF_RS1A +: 5];
                    rvfi_rs2_addr[i*5 +: 5]         <= ret_rec[i][OFF_RS2A +: 5];
                    rvfi_rd_addr[i*5 +: 5]          <= ret_rec[i][OFF_RD +: 5];
                    rvfi_rs1_rdata[i*XLEN +: XLEN]  <= ret_rec[i][OFF_RS1D +: XLEN];
                    rvfi_rs2_rdata[i*XLEN +: XLEN]  <= ret_rec[i][OFF_RS2D +: XLEN];
                    rvfi_rd_wdata[i*XLEN +: XLEN]   <= ret_rec[i][OFF_RDW +: XLEN];
                    rvfi_pc_rdata[i*XLEN +: XLEN]   <= ret_rec[i][OFF_PCR +: XLEN];
                    rvfi_pc_wdata[i*XLEN +: XLEN]   <= ret_rec[i][OFF_PCW +: XLEN];
                    rvfi_mem_addr[i*XLEN +: XLEN]   <= ret_rec[i][OFF_MADDR +: XLEN];
                    rvfi_mem_rmask[i*MW +: MW]      <= ret_rec[i][OFF_RMASK +: MW];
                    rvfi_mem_wmask[i*MW +: MW]      <= ret_rec[i][OFF_WMASK +: MW];
                    rvfi_mem_rdata[i*XLEN +: XLEN]  <= ret_rec[i][OFF_RDATA +: XLEN];
                    rvfi_mem_wdata[i*XLEN +: XLEN]  <= ret_rec[i][OFF_WDATA +: XLEN];
                end
            end
            // A retiring slot is full, so it can never be the accept target in the same cycle.
            if (in_valid && in_ready) begin
                slot_full_q[in_tag] <= 1'b1;
                slot_rec_q[in_tag]  <= in_rec;
            end
            head_q  <= head_q + TAG_W'(ret_cnt);
            order_q <= order_q + 64'(ret_cnt);
            if (ret_halt) begin
                mode_q <= ModeHalted;
            end
        end
    end

endmodule

// File: tb/tb_rvfi_retire_emitter.sv
// Scoreboard bench: three emitter configurations (NRET 1/2/4) driven with directed and random
// traffic, each checked against a slot-level reference model of the in-order retire rules.
module tb_rvfi_retire_emitter;
    localparam int XL = 32;
    localparam int IL = 32;
    localparam int RW = IL + 18 + 8 * XL + XL / 4;
    localparam int HB = RW - IL - 2;
    localparam int NCFG = 3;

    typedef struct {
        int          cyc;
        int          chan;
        logic [63:0] order;
        logic [RW-1:0] rec;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  checks = 0;
    int  failures = 0;
    bit  done [NCFG];

    task automatic check(input string name, input int g, input logic [RW-1:0] act,
                         input logic [RW-1:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s cfg%0d cyc=%0d got=%h want=%h", name, g, cyc, act, want);
        end
    endtask

    function automatic logic [RW-1:0] mk_rec(input bit halt);
        logic [319:0] t;
        logic [RW-1:0] r;
        for (int j = 0; j < 10; j++) t[j*32 +: 32] = $urandom;
        r = t[RW-1:0];
        r[HB] = halt;
        return r;
    endfunction

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int NR = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        localparam int DP = (g == 2) ? 4 : 8;
        localparam int TW = $clog2(DP);
        localparam int MW = XL / 8;

        logic              resetn, in_valid, in_ready, flush;
        logic [TW-1:0]     in_tag, flush_tag;
        logic [RW-1:0]     in_rec;
        logic [NR-1:0]     rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr;
        logic [64*NR-1:0]  rvfi_order;
        logic [IL*NR-1:0]  rvfi_insn;
        logic [5*NR-1:0]   rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
        logic [XL*NR-1:0]  rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
        logic [XL*NR-1:0]  rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr;
        logic [MW*NR-1:0]  rvfi_mem_rmask, rvfi_mem_wmask;
        logic [XL*NR-1:0]  rvfi_mem_rdata, rvfi_mem_wdata;

        rvfi_retire_emitter #(.NRET(NR), .XLEN(XL), .ILEN(IL), .DEPTH(DP)) dut (
            .clock(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
            .in_tag(in_tag), .in_rec(in_rec), .flush(flush), .flush_tag(flush_tag),
            .rvfi_valid(rvfi_valid), .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt),
            .rvfi_intr(rvfi_intr), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
            .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
            .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rs1_rdata(rvfi_rs1_rdata),
            .rvfi_rs2_rdata(rvfi_rs2_rdata), .rvfi_rd_wdata(rvfi_rd_wdata),
            .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
            .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
            .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_mem_rdata(rvfi_mem_rdata),
            .rvfi_mem_wdata(rvfi_mem_wdata)
        );

        // Reference model: which slots hold a record, where program order resumes, and
        // whether a halt has been emitted.
        bit            m_full [DP];
        logic [RW-1:0] m_rec [DP];
        int            m_head;
        logic [63:0]   m_order;
        bit            m_halted;
        exp_t          sb_q [$];
        bit            armed = 1'b0;
        bit            chk_zero = 1'b0;

        // Pack one channel back into the record layout: insn first, mem_wdata last.
        function automatic logic [RW-1:0] out_rec(input int i);
            return {rvfi_insn[i*IL +: IL], rvfi_trap[i], rvfi_halt[i], rvfi_intr[i],
                    rvfi_rs1_addr[i*5 +: 5], rvfi_rs2_addr[i*5 +: 5], rvfi_rd_addr[i*5 +: 5],
                    rvfi_rs1_rdata[i*XL +: XL], rvfi_rs2_rdata[i*XL +: XL],
                    rvfi_rd_wdata[i*XL +: XL], rvfi_pc_rdata[i*XL +: XL],
                    rvfi_pc_wdata[i*XL +: XL], rvfi_mem_addr[i*XL +: XL],
                    rvfi_mem_rmask[i*MW +: MW], rvfi_mem_wmask[i*MW +: MW],
                    rvfi_mem_rdata[i*XL +: XL], rvfi_mem_wdata[i*XL +: XL]};
        endfunction

        // One clock: drive after the edge, check ready and predict at negedge, return after edge.
        task automatic step(input bit rst, input bit v, input int tag, input logic [RW-1:0] rec,
                            input bit fl, input int ftag);
            bit acc, stop;
            int n, idx;
            exp_t e;
            tag = tag % DP;
            resetn    = !rst;
            in_valid  = v;
            in_tag    = TW'(tag);
            in_rec    = rec;
            flush     = fl;
            flush_tag = TW'(ftag % DP);
            @(negedge clk);
            if (chk_zero) begin
                for (int i = 0; i < NR; i++) begin
                    check("reset_valid", g, RW'(rvfi_valid[i]), '0);
                    check("reset_order", g, RW'(rvfi_order[i*64 +: 64]), '0);
                    check("reset_fields", g, out_rec(i), '0);
                end
            end
            check("in_ready", g, RW'(in_ready), RW'(!rst && !m_full[tag]));
            if (rst) begin
                foreach (m_full[i]) m_full[i] = 1'b0;
                m_head = 0;
                m_order = '0;
                m_halted = 1'b0;
            end else if (fl) begin
                foreach (m_full[i]) m_full[i] = 1'b0;
                m_head = ftag % DP;
            end else begin
                acc  = v && !m_full[tag];
                n    = 0;
                stop = m_halted;
                while (!stop && n < NR && m_full[(m_head + n) % DP]) begin
                    idx = (m_head + n) % DP;
                    e.cyc = cyc + 1;
                    e.chan = n;
                    e.order = m_order + 64'(n);
                    e.rec = m_rec[idx];
                    sb_q.push_back(e);
                    m_full[idx] = 1'b0;
                    if (m_rec[idx][HB]) begin
                        stop = 1'b1;
                        m_halted = 1'b1;
                    end
                    n++;
                end
                m_head = (m_head + n) % DP;
                m_order = m_order + 64'(n);
                if (acc) begin
                    m_full[tag] = 1'b1;
                    m_rec[tag] = rec;
                end
            end
            @(posedge clk);
            #1;
            chk_zero = rst;
        endtask

        task automatic put(input int tag, input bit halt);
            step(1'b0, 1'b1, tag, mk_rec(halt), 1'b0, 0);
        endtask

        task automatic idle(input int n);
            for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, '0, 1'b0, 0);
        endtask

        task automatic do_reset();
            step(1'b1, 1'b0, 0, '0, 1'b0, 0);
        endtask

        // Monitor: every channel every cycle must match the front of the scoreboard.
        initial begin
            exp_t e;
            bit expv;
            forever begin
                @(negedge clk);
                if (armed) begin
                    for (int i = 0; i < NR; i++) begin
                        expv = sb_q.size() > 0 && sb_q[0].cyc == cyc && sb_q[0].chan == i;
                        check("rvfi_valid", g, RW'(rvfi_valid[i]), RW'(expv));
                        if (expv) begin
                            e = sb_q.pop_front();
                            check("rvfi_order", g, RW'(rvfi_order[i*64 +: 64]), RW'(e.order));
                            check("rvfi_record", g, out_rec(i), e.rec);
                        end
                    end
                    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) void'(sb_q.pop_front());
                end
            end
        end

        initial begin
            int tag;
            resetn = 1'b0; in_valid = 1'b0; in_tag = '0; in_rec = '0;
            flush = 1'b0; flush_tag = '0;
            @(posedge clk);
            #1;
            do_reset();
            armed = 1'b1;
            do_reset();
            // In-order trickle.
            put(0, 0); put(1, 0); put(2, 0); idle(3);
            // Reverse arrival: nothing until the head slot lands.
            do_reset();
            put(2, 0); put(1, 0); put(0, 0); idle(4);
            // Occupied tag is back-pressured until it retires.
            do_reset();
            put(3, 0); put(3, 0); put(3, 0); put(0, 0); put(1, 0); put(2, 0); put(3, 0); idle(4);
            // Long in-order run wraps the head.
            do_reset();
            for (int i = 0; i < 20; i++) put(i, 0);
            idle(4);
            // Halt stops retirement for good; accepts continue.
            do_reset();
            put(0, 0); put(1, 1); put(2, 0); idle(3); put(3, 0); put(4, 0); idle(3);
            // Flush moves the head; reset restarts order.
            do_reset();
            put(2, 0); put(3, 0);
            step(1'b0, 1'b0, 0, '0, 1'b1, 5);
            put(5, 0); idle(2);
            do_reset();
            put(0, 0); idle(3);
            // Random traffic.
            do_reset();
            for (int c = 0; c < 1200; c++) begin
                if ($urandom_range(0, 2) != 0) tag = m_head + $urandom_range(0, NR);
                else tag = $urandom_range(0, DP - 1);
                step($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0, tag,
                     mk_rec($urandom_range(0, 49) == 0), $urandom_range(0, 59) == 0,
                     $urandom_range(0, DP - 1));
            end
            idle(3);
            check("sb_empty", g, RW'(sb_q.size()), '0);
            done[g] = 1'b1;
        end
    end

    initial begin
        bit all_done;
        all_done = 1'b0;
        for (int c = 0; c < 20000 && !all_done; c++) begin
            @(posedge clk);
            all_done = done[0] && done[1] && done[2];
        end
        check("finished", -1, RW'(all_done), RW'(1));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
